// File: rtl/branch_scoreboard_if.sv
// branch_scoreboard_if: prediction push, resolution and redirect signals between predictor, core and scoreboard
interface branch_scoreboard_if #(parameter int Direction_SIZE = 32);
  logic                      pred_valid;
  logic                      pred_ready;
  logic                      pred_taken;
  logic [Direction_SIZE-1:0] pred_pc;
  logic [Direction_SIZE-1:0] pred_target;
  logic                      res_valid;
  logic                      res_taken;
  logic [Direction_SIZE-1:0] res_target;
  logic                      mispredict;
  logic [Direction_SIZE-1:0] redirect_pc;
  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
    input  pred_ready, mispredict, redirect_pc
  );
  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target, res_valid, res_taken, res_target,
    output pred_ready, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_scoreboard.sv
// branch_scoreboard: in-order queue of predictions checked at resolution, with redirect on miss and saturating accuracy stats
module branch_scoreboard #(
  parameter int Direction_SIZE = 32,
  parameter int DEPTH          = 8,
  parameter int PC_STEP        = 4,
  parameter int CNT_W          = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  branch_scoreboard_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [CNT_W-1:0]             total_branch,
  output logic [CNT_W-1:0]             correct_cnt,
  output logic [CNT_W-1:0]             dir_miss_cnt,
  output logic [CNT_W-1:0]             tgt_miss_cnt,
  output logic                         underflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic                      q_taken  [DEPTH];
  logic [Direction_SIZE-1:0] q_pc     [DEPTH];
  logic [Direction_SIZE-1:0] q_target [DEPTH];
  logic [AW:0]               wptr, rptr, occ;
  logic                      push, pop, dir_miss, tgt_miss, miss;
  logic                      h_taken;
  logic [Direction_SIZE-1:0] h_pc, h_target, fix_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(c != '1);
  endfunction

  assign occ            = wptr - rptr;
  assign outstanding    = occ;
  assign h_taken        = q_taken[rptr[AW-1:0]];
  assign h_pc           = q_pc[rptr[AW-1:0]];
  assign h_target       = q_target[rptr[AW-1:0]];
  assign pop            = bus.res_valid & (occ != '0);
  assign bus.pred_ready = (occ < FULL) | pop;
  assign push           = bus.pred_valid & bus.pred_ready;
  assign dir_miss       = pop & (h_taken != bus.res_taken);
  assign tgt_miss       = pop & ~dir_miss & bus.res_taken & (h_target != bus.res_target);
  assign miss           = dir_miss | tgt_miss;
  assign fix_pc         = bus.res_taken ? bus.res_target : h_pc + Direction_SIZE'(PC_STEP);

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_taken[wptr[AW-1:0]]  <= bus.pred_taken;
      q_pc[wptr[AW-1:0]]     <= bus.pred_pc;
      q_target[wptr[AW-1:0]] <= bus.pred_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr            <= '0;
      rptr            <= '0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
      total_branch    <= '0;
      correct_cnt     <= '0;
      dir_miss_cnt    <= '0;
      tgt_miss_cnt    <= '0;
      underflow_err   <= 1'b0;
    end else begin
      // A miss empties the queue by snapping rptr to wptr and dropping any same-cycle push.
      if (push && !miss) wptr <= wptr + ONE;
      rptr            <= miss ? wptr : (pop ? rptr + ONE : rptr);
      bus.mispredict  <= miss;
      bus.redirect_pc <= miss ? fix_pc : bus.redirect_pc;
      total_branch    <= pop ? sat_inc(total_branch) : total_branch;
      correct_cnt     <= (pop && !miss) ? sat_inc(correct_cnt) : correct_cnt;
      dir_miss_cnt    <= dir_miss ? sat_inc(dir_miss_cnt) : dir_miss_cnt;
      tgt_miss_cnt    <= tgt_miss ? sat_inc(tgt_miss_cnt) : tgt_miss_cnt;
      underflow_err   <= underflow_err | (bus.res_valid & (occ == '0));
    end
  end
endmodule

// File: tb/tb_branch_scoreboard.sv
// tb_branch_scoreboard: scoreboard bench, model queue predicts per-cycle redirect/occupancy and accuracy stats
module tb_branch_scoreboard;
  typedef struct packed {logic taken; logic [31:0] pc; logic [31:0] target;} ent_t;
  typedef struct packed {logic miss; logic [31:0] redir;} exp_t;

  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] outstanding;
  logic [3:0] total_branch, correct_cnt, dir_miss_cnt, tgt_miss_cnt;
  logic       underflow_err;
  int         checks = 0, errors = 0;
  ent_t       mq[$];
  exp_t       exp_q[$];
  logic [3:0] m_tot, m_cor, m_dir, m_tgt;
  logic [31:0] m_redir;
  logic       m_under;

  branch_scoreboard_if #(.Direction_SIZE(32)) bus();

  branch_scoreboard #(.Direction_SIZE(32), .DEPTH(8), .PC_STEP(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .outstanding(outstanding),
    .total_branch(total_branch), .correct_cnt(correct_cnt), .dir_miss_cnt(dir_miss_cnt),
    .tgt_miss_cnt(tgt_miss_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sat(input logic [3:0] c);
    return (c == 4'hf) ? c : c + 4'd1;
  endfunction

  task automatic stats();
    chk("total_branch", total_branch, m_tot);
    chk("correct_cnt", correct_cnt, m_cor);
    chk("dir_miss_cnt", dir_miss_cnt, m_dir);
    chk("tgt_miss_cnt", tgt_miss_cnt, m_tgt);
    chk("underflow_err", underflow_err, m_under);
  endtask

  // Asserts reset right away (possibly mid-cycle) and checks outputs clear before any edge.
  task automatic do_reset();
    reset = 0;
    #1;
    mq.delete(); exp_q.delete();
    m_tot = 0; m_cor = 0; m_dir = 0; m_tgt = 0; m_redir = 0; m_under = 0;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    stats();
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                     input logic rv, input logic rt, input logic [31:0] rtg);
    ent_t h;
    exp_t e;
    logic pop, rdy, miss;
    bus.pred_valid = pv; bus.pred_taken = pt; bus.pred_pc = ppc; bus.pred_target = ptg;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtg;
    pop = rv && mq.size() != 0;
    rdy = mq.size() < 8 || pop;
    miss = 0;
    #1 chk("pred_ready", bus.pred_ready, rdy);
    if (pop) begin
      h = mq.pop_front();
      m_tot = sat(m_tot);
      if (h.taken != rt) begin m_dir = sat(m_dir); miss = 1; end
      else if (rt && h.target != rtg) begin m_tgt = sat(m_tgt); miss = 1; end
      else m_cor = sat(m_cor);
      if (miss) begin
        m_redir = rt ? rtg : h.pc + 32'd4;
        mq.delete();
      end
    end else if (rv) m_under = 1;
    if (pv && rdy && !miss) mq.push_back('{pt, ppc, ptg});
    exp_q.push_back('{miss, m_redir});
    @(posedge clk); #1;
    bus.pred_valid = 0; bus.res_valid = 0;
    e = exp_q.pop_front();
    chk("mispredict", bus.mispredict, e.miss);
    chk("redirect_pc", bus.redirect_pc, e.redir);
    chk("outstanding", outstanding, mq.size());
  endtask

  task automatic resolve_head(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg);
    cyc(pv, pt, ppc, ptg, 1, mq[0].taken, mq[0].target);
  endtask

  initial begin
    bus.pred_valid = 0; bus.pred_taken = 0; bus.pred_pc = 0; bus.pred_target = 0;
    bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
    do_reset();

    // Correct stream
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h10 * i, 32'h100, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1, 32'h100);
    stats();
    chk("correct_stream_cor", correct_cnt, 4);
    chk("correct_stream_tot", total_branch, 4);

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h20 + i, 32'h100, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h100);
    chk("pre_rst_outstanding", outstanding, 3);
    #3;
    do_reset();

    // Direction miss flushes the younger entry and drops the same-cycle push
    cyc(1, 0, 32'h40, 32'h48, 0, 0, 0);
    cyc(1, 1, 32'h44, 32'h60, 0, 0, 0);
    cyc(1, 1, 32'h48, 32'h70, 1, 1, 32'h80);
    chk("dir_redirect", bus.redirect_pc, 32'h80);
    chk("dir_outstanding", outstanding, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dir_hold_redirect", bus.redirect_pc, 32'h80);
    stats();
    chk("dir_miss_cnt1", dir_miss_cnt, 1);

    // Target miss, then fall-through redirect, then not-taken with different target counts as correct
    cyc(1, 1, 32'h30, 32'h200, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h204);
    chk("tgt_redirect", bus.redirect_pc, 32'h204);
    chk("tgt_miss_cnt1", tgt_miss_cnt, 1);
    cyc(1, 1, 32'h10, 32'h50, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h999);
    chk("ft_redirect", bus.redirect_pc, 32'h14);
    cyc(1, 0, 32'h60, 32'h123, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h456);
    stats();

    // Full, push-with-pop at full, and FIFO order across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 1'($urandom_range(0, 1)), 32'h1000 + i * 4, 32'h2000 + i * 8, 0, 0, 0);
    chk("full_ready", bus.pred_ready, 0);
    cyc(1, 1, 32'h3000, 32'h3100, 0, 0, 0);
    resolve_head(1, 1, 32'h3004, 32'h3104);
    chk("full_pushpop_occ", outstanding, 8);
    for (int i = 0; i < 20; i++) resolve_head(1, 1'($urandom_range(0, 1)), 32'h4000 + i * 4, 32'h5000 + i * 16);
    for (int i = 0; i < 8; i++) resolve_head(0, 0, 0, 0);
    stats();
    chk("wrap_dir_miss", dir_miss_cnt, 0);
    chk("wrap_tgt_miss", tgt_miss_cnt, 0);

    // Underflow is sticky and leaves counters alone; correct_cnt saturates
    do_reset();
    cyc(0, 0, 0, 0, 1, 1, 32'h100);
    chk("underflow_set", underflow_err, 1);
    chk("underflow_total", total_branch, 0);
    cyc(1, 1, 32'h70, 32'h700, 0, 0, 0);
    for (int i = 0; i < 16; i++) resolve_head(1, 1, 32'h70 + i * 4, 32'h700);
    resolve_head(0, 0, 0, 0);
    stats();
    chk("sat_correct", correct_cnt, 15);
    chk("sat_total", total_branch, 15);
    chk("underflow_sticky", underflow_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
